mvu_weight_mem_rt: RTL and testbench



---
 rtl/mvu_rt_pkg.sv | 19 +
 rtl/mvu_weight_bank.sv | 61 ++++++
 rtl/mvu_weight_mem_rt.sv | 138 +++++++++++++
 tb/tb_mvu_weight_mem_rt.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_rt_pkg.sv
// ----------------------------------------------------------------------------
// mvu_rt_pkg
//   Shared types and helpers for the runtime-reloadable MVAU weight memory.
//   - wmem_state_t : load sequencer state (IDLE / LOAD / READY)
//   - clog2_min1   : ceil(log2(n)) clamped to at least 1, for counter widths
// ----------------------------------------------------------------------------
package mvu_rt_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      READY
   } wmem_state_t;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mvu_weight_bank.sv
// ----------------------------------------------------------------------------
// mvu_weight_bank
//   One PE's simple-dual-port weight RAM with a registered read port.
//   Ports:
//     clk    in   clock for both ports
//     rst_n  in   synchronous active-low reset (read register only)
//     we     in   write enable
//     waddr  in   write address
//     wdata  in   write word (SIMD*TW bits)
//     re     in   read enable; rdata updates on the next edge
//     raddr  in   read address
//     rdata  out  registered read word, holds when re=0
// ----------------------------------------------------------------------------
module mvu_weight_bank
   import mvu_rt_pkg::*;
#(
   parameter int unsigned SIMD       = 2,
   parameter int unsigned TW         = 1,
   parameter int unsigned WMEM_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              we,
   input  logic [clog2_min1(WMEM_DEPTH)-1:0] waddr,
   input  logic [SIMD*TW-1:0]                wdata,
   input  logic                              re,
   input  logic [clog2_min1(WMEM_DEPTH)-1:0] raddr,
   output logic [SIMD*TW-1:0]                rdata
);

   localparam int unsigned W = SIMD * TW;

   // RAM array is intentionally not reset so it maps onto block/distributed RAM
   logic [W-1:0] mem [WMEM_DEPTH];
   logic [W-1:0] rdata_q;
   logic [W-1:0] rdata_d;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem[raddr];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mvu_weight_mem_rt.sv
// ----------------------------------------------------------------------------
// mvu_weight_mem_rt
//   Runtime-reloadable, PE-banked weight memory for the MVAU datapath.
//   A weight stream is scattered PE-fastest into PE banks by a load
//   sequencer; the compute side reads all banks at one address.
//   Ports:
//     clock          in   single clock
//     aresetn        in   synchronous active-low reset
//     load_start     in   pulse: begin a full weight reload
//     s_wdata        in   weight word for one PE at one address
//     s_wvalid       in   write-stream valid
//     s_wready       out  write-stream ready (high only while loading)
//     weights_ready  out  memory holds a complete weight set
//     load_busy      out  reload in progress
//     rd_en          in   read request (honoured only while weights_ready)
//     rd_addr        in   read address
//     wmem_out       out  per-PE read data, holds between reads
//     wmem_valid     out  wmem_out valid this cycle (latency 1 from rd_en)
// ----------------------------------------------------------------------------
module mvu_weight_mem_rt
   import mvu_rt_pkg::*;
#(
   parameter int unsigned SIMD         = 2,
   parameter int unsigned PE           = 2,
   parameter int unsigned TW           = 1,
   parameter int unsigned WMEM_DEPTH   = 4,
   parameter int unsigned WMEM_ADDR_BW = clog2_min1(WMEM_DEPTH),
   parameter int unsigned PE_BW        = clog2_min1(PE)
) (
   input  logic                    clock,
   input  logic                    aresetn,
   input  logic                    load_start,
   input  logic [SIMD*TW-1:0]      s_wdata,
   input  logic                    s_wvalid,
   output logic                    s_wready,
   output logic                    weights_ready,
   output logic                    load_busy,
   input  logic                    rd_en,
   input  logic [WMEM_ADDR_BW-1:0] rd_addr,
   output logic [SIMD*TW-1:0]      wmem_out [0:PE-1],
   output logic                    wmem_valid
);

   wmem_state_t             state_q, state_d;
   logic [PE_BW-1:0]        pe_cnt_q, pe_cnt_d;
   logic [WMEM_ADDR_BW-1:0] addr_cnt_q, addr_cnt_d;
   logic                    wmem_valid_q, wmem_valid_d;

   logic wr_fire;
   logic rd_fire;

   // Reads are gated by READY, so a bank never sees a read and write together
   assign wr_fire = (state_q == LOAD) && s_wvalid;
   assign rd_fire = (state_q == READY) && rd_en;

   // State register
   always_ff @(posedge clock) begin
      if (!aresetn) begin
         state_q      <= IDLE;
         pe_cnt_q     <= '0;
         addr_cnt_q   <= '0;
         wmem_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pe_cnt_q     <= pe_cnt_d;
         addr_cnt_q   <= addr_cnt_d;
         wmem_valid_q <= wmem_valid_d;
      end
   end

   // Next-state and fill counters (PE-fastest order)
   always_comb begin
      state_d    = state_q;
      pe_cnt_d   = pe_cnt_q;
      addr_cnt_d = addr_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (load_start) begin
               state_d    = LOAD;
               pe_cnt_d   = '0;
               addr_cnt_d = '0;
            end
         end
         LOAD: begin
            // load_start is ignored here: the running load always completes
            if (wr_fire) begin
               if (pe_cnt_q == PE_BW'(PE - 1)) begin
                  pe_cnt_d = '0;
                  if (addr_cnt_q == WMEM_ADDR_BW'(WMEM_DEPTH - 1)) begin
                     addr_cnt_d = '0;
                     state_d    = READY;
                  end else begin
                     addr_cnt_d = addr_cnt_q + WMEM_ADDR_BW'(1);
                  end
               end else begin
                  pe_cnt_d = pe_cnt_q + PE_BW'(1);
               end
            end
         end
         READY: begin
            if (load_start) begin
               state_d    = LOAD;
               pe_cnt_d   = '0;
               addr_cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      s_wready      = (state_q == LOAD);
      load_busy     = (state_q == LOAD);
      weights_ready = (state_q == READY);
      wmem_valid_d  = rd_fire;
   end

   assign wmem_valid = wmem_valid_q;

   for (genvar p = 0; p < PE; p++) begin : g_bank
      mvu_weight_bank #(
         .SIMD       (SIMD),
         .TW         (TW),
         .WMEM_DEPTH (WMEM_DEPTH)
      ) u_bank (
         .clk   (clock),
         .rst_n (aresetn),
         .we    (wr_fire && (pe_cnt_q == PE_BW'(p))),
         .waddr (addr_cnt_q),
         .wdata (s_wdata),
         .re    (rd_fire),
         .raddr (rd_addr),
         .rdata (wmem_out[p])
      );
   end

endmodule

// File: tb/tb_mvu_weight_mem_rt.sv
// ----------------------------------------------------------------------------
// tb_mvu_weight_mem_rt
//   Scoreboard bench for mvu_weight_mem_rt: stimulus updates a reference
//   memory model and queues expected read data; a monitor compares every
//   valid read (data and latency) and checks that wmem_out holds otherwise.
// ----------------------------------------------------------------------------
module tb_mvu_weight_mem_rt;

   localparam int SIMD  = 2;
   localparam int PE    = 2;
   localparam int TW    = 4;
   localparam int DEPTH = 4;
   localparam int W     = SIMD * TW;
   localparam int ABW   = 2;
   localparam int NW    = PE * DEPTH;

   logic           clock = 1'b0;
   logic           aresetn;
   logic           load_start;
   logic [W-1:0]   s_wdata;
   logic           s_wvalid;
   logic           s_wready;
   logic           weights_ready;
   logic           load_busy;
   logic           rd_en;
   logic [ABW-1:0] rd_addr;
   logic [W-1:0]   wmem_out [0:PE-1];
   logic           wmem_valid;

   always #5 clock = ~clock;

   mvu_weight_mem_rt #(
      .SIMD       (SIMD),
      .PE         (PE),
      .TW         (TW),
      .WMEM_DEPTH (DEPTH)
   ) dut (
      .clock         (clock),
      .aresetn       (aresetn),
      .load_start    (load_start),
      .s_wdata       (s_wdata),
      .s_wvalid      (s_wvalid),
      .s_wready      (s_wready),
      .weights_ready (weights_ready),
      .load_busy     (load_busy),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .wmem_out      (wmem_out),
      .wmem_valid    (wmem_valid)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int busy_cnt = 0;

   // Reference model: weight set as a plain 2-D array plus load progress
   logic [W-1:0] ref_mem [PE][DEPTH];
   bit           m_loading = 1'b0;
   bit           m_ready   = 1'b0;
   int           m_cnt     = 0;

   typedef struct {
      logic [PE*W-1:0] data;
      int              cyc;
   } exp_t;
   exp_t exp_q[$];

   logic [W-1:0]    wbuf [NW];
   logic [PE*W-1:0] act;
   logic [PE*W-1:0] last_out = '0;

   function automatic void chk1(input string n, input logic a, input bit e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %b exp %b (cycle %0d)", n, a, e, cyc);
      end
   endfunction

   // Monitor: samples 1 time unit after each rising edge
   always @(posedge clock) begin
      #1;
      cyc++;
      for (int p = 0; p < PE; p++) act[p*W +: W] = wmem_out[p];
      if (aresetn !== 1'b1) begin
         checks++;
         if (wmem_valid !== 1'b0 || act !== '0) begin
            errors++;
            $display("FAIL reset_out got valid=%b data=%h exp valid=0 data=0", wmem_valid, act);
         end
         last_out = '0;
      end else if (wmem_valid !== 1'b0) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid got valid=%b exp 0 (cycle %0d)", wmem_valid, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (act !== e.data) begin
               errors++;
               $display("FAIL rd_data got %h exp %h (cycle %0d)", act, e.data, cyc);
            end
            checks++;
            if (cyc != e.cyc) begin
               errors++;
               $display("FAIL rd_latency got cycle %0d exp cycle %0d", cyc, e.cyc);
            end
         end
         last_out = act;
      end else begin
         checks++;
         if (act !== last_out) begin
            errors++;
            $display("FAIL out_hold got %h exp %h (cycle %0d)", act, last_out, cyc);
         end
      end
   end

   // One clock of stimulus: check control outputs against the model, drive
   // inputs, then advance the model to what the next rising edge must do.
   task automatic step(input bit ls, input bit sv, input logic [W-1:0] sd,
                       input bit re, input logic [ABW-1:0] ra, input bit rn);
      exp_t e;
      @(negedge clock);
      chk1("s_wready", s_wready, m_loading);
      chk1("load_busy", load_busy, m_loading);
      chk1("weights_ready", weights_ready, m_ready);
      if (load_busy === 1'b1) busy_cnt++;
      load_start = ls;
      s_wvalid   = sv;
      s_wdata    = sd;
      rd_en      = re;
      rd_addr    = ra;
      aresetn    = rn;
      if (!rn) begin
         m_loading = 1'b0;
         m_ready   = 1'b0;
      end else begin
         if (re && m_ready) begin
            for (int p = 0; p < PE; p++) e.data[p*W +: W] = ref_mem[p][int'(ra)];
            e.cyc = cyc + 1;
            exp_q.push_back(e);
         end
         if (m_loading) begin
            if (sv) begin
               ref_mem[m_cnt % PE][m_cnt / PE] = sd;
               m_cnt++;
               if (m_cnt == NW) begin
                  m_loading = 1'b0;
                  m_ready   = 1'b1;
               end
            end
         end else if (ls) begin
            m_loading = 1'b1;
            m_ready   = 1'b0;
            m_cnt     = 0;
         end
      end
   endtask

   task automatic idle();
      step(0, 0, '0, 0, '0, 1);
   endtask

   task automatic rd(input logic [ABW-1:0] a);
      step(0, 0, '0, 1, a, 1);
   endtask

   // mode 0: back-to-back, 1: valid toggles starting low,
   // 2: random stalls with stray load_start / rd_en during the load
   task automatic load(input int mode, input bit rd_with_start, input logic [ABW-1:0] ra);
      int k = 0;
      int n = 0;
      bit tog = 1'b0;
      bit sv, ls, re;
      step(1, 0, '0, rd_with_start, ra, 1);
      while (k < NW && n < 200) begin
         sv  = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
         tog = !tog;
         ls  = (mode == 2) && ($urandom_range(0, 5) == 0);
         re  = (mode == 2) && ($urandom_range(0, 3) == 0);
         step(ls, sv, wbuf[k], re, ABW'($urandom_range(0, DEPTH - 1)), 1);
         if (sv) k++;
         n++;
      end
      if (k < NW) begin
         checks++;
         errors++;
         $display("FAIL load_timeout got %0d words exp %0d", k, NW);
      end
   endtask

   initial begin
      aresetn    = 1'b0;
      load_start = 1'b0;
      s_wvalid   = 1'b0;
      s_wdata    = '0;
      rd_en      = 1'b0;
      rd_addr    = '0;

      repeat (3) step(0, 0, '0, 0, '0, 0);
      repeat (2) idle();
      rd(0);
      rd(0);
      step(0, 1, 8'hEE, 0, '0, 1);
      idle();

      // Sequential pattern, back-to-back
      for (int i = 0; i < NW; i++) wbuf[i] = 8'(8'h11 * (i + 1));
      load(0, 0, '0);
      idle();
      rd(0); idle(); rd(3); idle();
      for (int a = 0; a < DEPTH; a++) rd(ABW'(a));
      idle(); idle();

      // Same pattern with valid toggling; load must stay busy 16 cycles
      busy_cnt = 0;
      load(1, 0, '0);
      idle();
      checks++;
      if (busy_cnt != 16) begin
         errors++;
         $display("FAIL busy_cycles got %0d exp 16", busy_cnt);
      end
      for (int a = 0; a < DEPTH; a++) rd(ABW'(a));
      idle();

      // Reload from READY, with a read issued on the load_start cycle
      for (int i = 0; i < NW; i++) wbuf[i] = 8'(8'hF0 + i);
      load(0, 1, 2'd1);
      idle();
      rd(2); idle();

      // Reset after 3 of 8 words, then a fresh full load
      step(1, 0, '0, 0, '0, 1);
      for (int i = 0; i < 3; i++) step(0, 1, 8'(8'hA0 + i), 0, '0, 1);
      step(0, 0, '0, 0, '0, 0);
      idle(); idle();
      rd(1);
      for (int i = 0; i < NW; i++) wbuf[i] = 8'($urandom);
      load(2, 0, '0);
      for (int a = 0; a < DEPTH; a++) rd(ABW'(a));
      idle();

      // Randomised loads and read bursts
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < NW; i++) wbuf[i] = 8'($urandom);
         load(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
              ABW'($urandom_range(0, DEPTH - 1)));
         for (int c = 0; c < 20; c++)
            step(0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 ABW'($urandom_range(0, DEPTH - 1)), 1);
      end

      repeat (3) idle();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_reads got %0d pending exp 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
